// File: rtl/ddr_line_master_if.sv
// Client request/response and Wishbone line bus bundle for ddr_line_master.
// The engine takes the master modport; the client/slave side takes slave.
interface ddr_line_master_if;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [31:0]  req_addr;
    logic [511:0] req_wdata;
    logic [63:0]  req_dm;
    logic         rsp_valid;
    logic         rsp_err;
    logic [511:0] rsp_rdata;
    logic [31:0]  wm_addr;
    logic [511:0] wm_dout;
    logic [63:0]  wm_dm;
    logic         wm_cyc;
    logic         wm_stb;
    logic         wm_we;
    logic         wm_ack;
    logic [511:0] wm_din;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_dm,
        input  wm_ack, wm_din,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output wm_addr, wm_dout, wm_dm, wm_cyc, wm_stb, wm_we
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_dm,
        output wm_ack, wm_din,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  wm_addr, wm_dout, wm_dm, wm_cyc, wm_stb, wm_we
    );
endinterface

// File: rtl/ddr_line_master.sv
// Single-line Wishbone classic master toward the DDR3 slave port:
// one 512-bit read or write per request, aborting after TIMEOUT bus cycles.
module ddr_line_master #(
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    ddr_line_master_if.master  bus,
    output logic [1:0]         dbg_state,
    output logic [7:0]         dbg_timeouts
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01
    } state_t;

    localparam int          CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    addr_q, addr_d;
    logic [511:0]   dout_q, dout_d;
    logic [63:0]    dm_q, dm_d;
    logic           we_q, we_d;
    logic           cyc_q, cyc_d;
    logic           rv_q, rv_d;
    logic           err_q, err_d;
    logic [511:0]   rdata_q, rdata_d;
    logic [7:0]     tmo_q, tmo_d;
    logic           unused_addr;

    assign unused_addr = ^bus.req_addr[5:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        dm_d    = dm_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        rv_d    = 1'b0;
        err_d   = err_q;
        rdata_d = rdata_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                // a late ack landing here is deliberately ignored
                if (bus.req_valid) begin
                    state_d = BUS;
                    addr_d  = {bus.req_addr[31:6], 6'b0};
                    dout_d  = bus.req_wdata;
                    dm_d    = bus.req_dm;
                    we_d    = bus.req_we;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            BUS: begin
                if (bus.wm_ack) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    rv_d    = 1'b1;
                    err_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = bus.wm_din;
                    end
                end else if (cnt_q == TC) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    rv_d    = 1'b1;
                    err_d   = 1'b1;
                    if (tmo_q != 8'hFF) begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            dm_q    <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            dm_q    <= dm_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rv_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.wm_addr   = addr_q;
    assign bus.wm_dout   = dout_q;
    assign bus.wm_dm     = dm_q;
    assign bus.wm_cyc    = cyc_q;
    assign bus.wm_stb    = cyc_q;
    assign bus.wm_we     = we_q;
    assign dbg_state     = state_q;
    assign dbg_timeouts  = tmo_q;
endmodule

// File: tb/tb_ddr_line_master.sv
// Bench for ddr_line_master: vector table, hand sequences and random
// transactions checked against a transaction-level model.
module tb_ddr_line_master;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;
    logic [7:0] dbg_timeouts;

    ddr_line_master_if bus();

    ddr_line_master #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .dbg_state    (dbg_state),
        .dbg_timeouts (dbg_timeouts)
    );

    always #5 clk = ~clk;

    int           n_chk  = 0;
    int           n_pass = 0;
    logic [511:0] m_rdata;
    int           m_tmo;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [63:0] dm;
        int          d;
        logic [31:0] exp_addr;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // d = BUS cycle index (0-based) carrying ack; >= TO means never.
    // lat = cycles from the request cycle to the rsp_valid cycle.
    task automatic run_txn(input logic we, input logic [31:0] a,
                           input logic [511:0] wd, input logic [63:0] dm,
                           input logic [511:0] din, input int d,
                           output int lat, output logic err,
                           output logic [511:0] rd, output logic [31:0] wa);
        @(negedge clk);
        chk("ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_dm    = dm;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        wa = bus.wm_addr;
        chk("cyc_up", bus.wm_cyc, 1);
        chk("stb_up", bus.wm_stb, 1);
        chk("ready_bus", bus.req_ready, 0);
        chk("wm_addr", bus.wm_addr, {a[31:6], 6'b0});
        chk("wm_we", bus.wm_we, we);
        chk("wm_dout", bus.wm_dout, wd);
        chk("wm_dm", bus.wm_dm, dm);
        lat = -1;
        err = 1'bx;
        rd  = 'x;
        for (int e = 1; e <= TO + 4; e++) begin
            @(negedge clk);
            bus.wm_ack = (e - 1 == d);
            bus.wm_din = din;
            @(posedge clk);
            #1;
            bus.wm_ack = 1'b0;
            if (bus.rsp_valid) begin
                lat = e + 1;
                break;
            end
        end
        if (lat > 0) begin
            err = bus.rsp_err;
            rd  = bus.rsp_rdata;
            chk("cyc_low_rsp", bus.wm_cyc, 0);
            chk("addr_hold", bus.wm_addr, {a[31:6], 6'b0});
            @(posedge clk);
            #1;
            chk("rsp_pulse", bus.rsp_valid, 0);
        end
    endtask

    task automatic model_txn(input logic we, input logic [511:0] din,
                             input int d, input int lat, input logic err,
                             input logic [511:0] rd);
        logic e_err;
        int   e_lat;
        e_err = (d >= TO);
        e_lat = ((d + 1 < TO) ? d + 1 : TO) + 1;
        if (!e_err && !we) m_rdata = din;
        if (e_err && m_tmo < 255) m_tmo++;
        chk("lat", lat, e_lat);
        chk("rsp_err", err, e_err);
        chk("rsp_rdata", rd, m_rdata);
        chk("dbg_timeouts", dbg_timeouts, m_tmo);
    endtask

    task automatic do_txn(input logic we, input logic [31:0] a,
                          input logic [63:0] dm, input int d);
        logic [511:0] wd, din, rd;
        logic [31:0]  wa;
        logic         err;
        int           lat;
        wd  = rnd512();
        din = rnd512();
        run_txn(we, a, wd, dm, din, d, lat, err, rd, wa);
        model_txn(we, din, d, lat, err, rd);
    endtask

    vec_t         tv[5];
    logic [511:0] dins[3];
    logic [511:0] wd, din, rd;
    logic [31:0]  wa;
    logic         err;
    int           lat;

    initial begin
        tv[0] = '{1'b0, 32'h1000_0047, 64'h0, 4, 32'h1000_0040, 1'b0, 6};
        tv[1] = '{1'b1, 32'h2000_013F, 64'hFF, 0, 32'h2000_0100, 1'b0, 2};
        tv[2] = '{1'b0, 32'h3000_0000, 64'h0, TO - 1, 32'h3000_0000, 1'b0, TO + 1};
        tv[3] = '{1'b1, 32'h0000_0080, '1, TO - 2, 32'h0000_0080, 1'b0, TO};
        tv[4] = '{1'b0, 32'hFFFF_FFFF, 64'h0, 100, 32'hFFFF_FFC0, 1'b1, TO + 1};

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_dm    = '0;
        bus.wm_ack    = 1'b0;
        bus.wm_din    = '0;
        m_rdata       = '0;
        m_tmo         = 0;

        #12;
        chk("rst_cyc", bus.wm_cyc, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_addr", bus.wm_addr, 0);
        chk("rst_rdata", bus.rsp_rdata, 0);
        chk("rst_state", dbg_state, 0);
        chk("rst_tmo", dbg_timeouts, 0);
        chk("rst_ready", bus.req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            wd  = {16{32'hC0DE_0000 + i}};
            din = (i == 0) ? {64{8'hA5}} : {16{32'h5A5A_0000 + i}};
            run_txn(tv[i].we, tv[i].addr, wd, tv[i].dm, din, tv[i].d,
                    lat, err, rd, wa);
            chk("tbl_addr", wa, tv[i].exp_addr);
            chk("tbl_err", err, tv[i].exp_err);
            chk("tbl_lat", lat, tv[i].exp_lat);
            model_txn(tv[i].we, din, tv[i].d, lat, err, rd);
        end
        chk("tbl_rdata_a5", bus.rsp_rdata, {16{32'h5A5A_0002}});

        // stray ack after the timeout abort
        @(negedge clk);
        bus.wm_ack = 1'b1;
        bus.wm_din = rnd512();
        @(posedge clk);
        #1;
        bus.wm_ack = 1'b0;
        chk("stray_rsp", bus.rsp_valid, 0);
        chk("stray_state", dbg_state, 0);
        @(posedge clk);
        #1;
        chk("stray_rsp2", bus.rsp_valid, 0);
        chk("stray_rdata", bus.rsp_rdata, m_rdata);

        // back-to-back with req_valid held high: read, write, read
        begin
            int idx = 0, bc = 0, rises = 0, rsps = 0;
            logic prev = 1'b0, acc, hold_chk = 1'b0;
            for (int i = 0; i < 3; i++) dins[i] = rnd512();
            for (int c = 0; c < 200 && rsps < 3; c++) begin
                @(negedge clk);
                bus.req_valid = (idx < 3);
                bus.req_we    = (idx == 1);
                bus.req_addr  = 32'h4000_0000 + 32'(idx) * 32'h40;
                bus.req_wdata = rnd512();
                bus.req_dm    = '1;
                bc            = bus.wm_cyc ? bc + 1 : 0;
                bus.wm_ack    = (bc == 2);
                bus.wm_din    = dins[(idx > 0) ? idx - 1 : 0];
                acc           = bus.req_ready && bus.req_valid;
                @(posedge clk);
                if (acc) idx++;
                #1;
                bus.wm_ack = 1'b0;
                if (bus.wm_cyc && !prev) rises++;
                prev = bus.wm_cyc;
                if (!hold_chk && idx == 3 && bus.wm_cyc) begin
                    hold_chk = 1'b1;
                    chk("b2b_hold", bus.rsp_rdata, dins[0]);
                end
                if (bus.rsp_valid) begin
                    chk("b2b_err", bus.rsp_err, 0);
                    chk("b2b_rdata", bus.rsp_rdata, dins[(rsps == 2) ? 2 : 0]);
                    rsps++;
                end
            end
            bus.req_valid = 1'b0;
            chk("b2b_rsps", rsps, 3);
            chk("b2b_rises", rises, 3);
            m_rdata = dins[2];
        end

        // asynchronous reset in the middle of a write
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h5000_0000;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cyc", bus.wm_cyc, 0);
        chk("arst_stb", bus.wm_stb, 0);
        chk("arst_we", bus.wm_we, 0);
        chk("arst_rsp", bus.rsp_valid, 0);
        chk("arst_tmo", dbg_timeouts, 0);
        chk("arst_rdata", bus.rsp_rdata, 0);
        m_rdata = '0;
        m_tmo   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(1'b0, 32'h6000_0010, 64'h0, 2);

        for (int i = 0; i < 60; i++) begin
            do_txn(1'($urandom), $urandom, {$urandom, $urandom},
                   int'($urandom_range(0, TO + 3)));
        end

        for (int i = 0; i < 300; i++) begin
            do_txn(1'b0, $urandom, 64'h0, TO + 10);
        end
        chk("tmo_sat", dbg_timeouts, 255);
        do_txn(1'b0, 32'h7000_0000, 64'h0, TO - 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ddr_line_master.md
# ddr_line_master

Wishbone master engine that issues 512-bit cache-line reads and writes toward the DDR3 Wishbone slave port on the memory side of the SoC. It accepts one line request at a time from a client (cache refill/writeback logic), drives a single Wishbone classic cycle, returns read data or write completion, and aborts with an error flag if the slave never acknowledges. It runs in the memory UI clock domain, the clock the DDR3 wrapper exports, so no CDC is involved.

## Interface
- TIMEOUT, 1024: cycles in BUS state without `wm_ack` before abort; legal range 2..65535.
- clk  in  1  UI clock from the DDR3 wrapper; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  client request present.
- req_ready  out  1  engine can accept a request this cycle.
- req_we  in  1  1 = line write, 0 = line read.
- req_addr  in  32  byte address; bits [5:0] are ignored.
- req_wdata  in  512  write line.
- req_dm  in  64  byte enables for the write line, 1 = write byte.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  valid with rsp_valid; 1 = timeout abort.
- rsp_rdata  out  512  read line, held until the next successful read.
- wm_addr  out  32  Wishbone address, bits [5:0] are always 0.
- wm_dout  out  512  Wishbone write data.
- wm_dm  out  64  Wishbone byte enables.
- wm_cyc, wm_stb  out  1 each  Wishbone cycle and strobe, always equal.
- wm_we  out  1  Wishbone write enable.
- wm_ack  in  1  Wishbone acknowledge.
- wm_din  in  512  Wishbone read data.
- dbg_state  out  2  current FSM state encoding.
- dbg_timeouts  out  8  saturating count of timeout aborts.

## Operation
- States: IDLE=2'b00 and BUS=2'b01. Any other encoding returns to IDLE.
- IDLE: `req_ready`=1. If `req_valid` is 1 at an edge, the engine does the following at that edge:
  - registers `wm_addr`={req_addr[31:6],6'b0}, `wm_we`, `wm_dout`, `wm_dm`;
  - sets `wm_cyc`/`wm_stb`=1, clears the timeout counter and enters BUS.
- BUS: `req_ready`=0. Address, data, mask and `wm_we` stay stable.
  - `wm_ack`=1 at an edge: clear cyc/stb, pulse `rsp_valid`=1 with `rsp_err`=0, return to IDLE. On a read, capture `wm_din` into `rsp_rdata` at that edge.
  - No ack and counter==TIMEOUT-1: clear cyc/stb, pulse `rsp_valid`=1 with `rsp_err`=1, leave `rsp_rdata` unchanged, increment `dbg_timeouts` (saturates at 255), return to IDLE.
  - Otherwise increment the counter. Its width is clog2(TIMEOUT).
- `wm_ack` sampled while in IDLE (a late ack after an abort) is ignored: no response is generated and no data is captured.
- `rsp_valid` is high for exactly one cycle per accepted request.
- `rsp_err` is cleared at every successful completion and holds its last value otherwise.
- Reset (asynchronous, whether idle or mid-transaction) forces the following immediately:
  - state=IDLE; `wm_cyc`=`wm_stb`=`wm_we`=0;
  - `wm_addr`=0, `wm_dout`=0, `wm_dm`=0;
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0;
  - `dbg_timeouts`=0, counter=0.
  
  No response is issued for an in-flight request.

## Timing
- Request accepted at edge A: cyc/stb is high from the cycle after A.
- Ack sampled at edge B: cyc/stb is low in the cycle after B, and `rsp_valid` is high in that same cycle.
- Because of this one-cycle turnaround the slave sees cyc low before it returns to ready, so it never re-samples a finished request. This holds when ack is a single-cycle pulse.
- `req_ready` goes high in the `rsp_valid` cycle. A new request is accepted at the end of that cycle at the earliest, so at least one idle bus cycle separates consecutive transactions.
- Minimum request-to-response latency is 2 cycles (ack in the first BUS cycle).
- A timeout abort happens at the edge where the engine has spent TIMEOUT cycles in BUS. `rsp_valid` (with `rsp_err`=1) is high in the following cycle.
- An ack that arrives at the same edge as the timeout terminal count wins: the request completes normally with `rsp_err`=0.

## Test plan
- Read with ack 5 cycles after cyc: request at 0x1000_0047 with `wm_din`=512'hA5…A5 → `wm_addr`=0x1000_0040, `wm_we`=0; `rsp_valid` one cycle after ack; `rsp_rdata`=A5…A5; `rsp_err`=0.
- Write with `req_dm`=64'h0000_0000_0000_00FF and ack on the first BUS cycle → `wm_dm`/`wm_dout` match the request; `rsp_valid` exactly 2 cycles after acceptance; `rsp_rdata` unchanged.
- TIMEOUT=16 and no ack → cyc drops after 16 BUS cycles; `rsp_valid`=1 with `rsp_err`=1; `dbg_timeouts`=1. A later stray ack in IDLE produces no response.
- Back-to-back requests with `req_valid` held high (read, then write, then read) → cyc is low for at least one cycle between transactions; three `rsp_valid` pulses in order; the second read's data does not overwrite the first until its own ack.
- Reset asserted mid-BUS → cyc/stb/rsp_valid are 0 asynchronously, before the next edge. After release, a fresh read completes normally.
- 300 forced timeouts → `dbg_timeouts` saturates at 255. An ack on the terminal-count edge completes with `rsp_err`=0.
